// File: rtl/block_bx_router_pkg.sv
// Shared B-subsystem types: destination tag, C-channel handshake states, counter helper.
package hierIncludeB_package;

    localparam int unsigned BX_DESTW = 4;

    typedef logic [BX_DESTW-1:0] bx_dest_t;

    typedef enum logic [1:0] {C_IDLE, C_REQ, C_REL} bx_c_state_t;

    function automatic logic [15:0] bx_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/block_bx_router_chan_fifo.sv
// Per-output synchronous FIFO; head data is presented whenever the FIFO is non-empty.
module bx_chan_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/block_bx_router.sv
// Routes one tagged rdy_vld stream to NUM_OUT buffered outputs, all of them, or a 4-phase C link.
module block_bx_router
    import hierIncludeB_package::*;
#(
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DESTW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DW-1:0]         in_data,
    input  logic [DESTW-1:0]      in_dest,
    output logic [NUM_OUT-1:0]    out_vld,
    input  logic [NUM_OUT-1:0]    out_rdy,
    output logic [NUM_OUT*DW-1:0] out_data,
    output logic                  c_req,
    input  logic                  c_ack,
    output logic [DW-1:0]         c_data,
    output logic [15:0]           drop_cnt
);

    localparam logic [DESTW-1:0] BX_DEST_C     = DESTW'(NUM_OUT);
    localparam logic [DESTW-1:0] BX_DEST_BCAST = '1;

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] empty;
    logic [NUM_OUT-1:0] push;
    logic               is_uni;
    logic               is_c;
    logic               is_bcast;
    logic               is_drop;
    logic               uni_full;
    logic               accept;
    bx_c_state_t        state;
    bx_c_state_t        state_nxt;

    always_comb begin
        is_uni   = (in_dest < BX_DEST_C);
        is_c     = (in_dest == BX_DEST_C);
        is_bcast = (in_dest == BX_DEST_BCAST);
        is_drop  = !is_uni && !is_c && !is_bcast;
        uni_full = 1'b0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (in_dest == DESTW'(i)) uni_full = full[i];
        end
        // Readiness looks only at registered FIFO/FSM state, never at out_rdy.
        if (rst)           in_rdy = 1'b0;
        else if (is_uni)   in_rdy = !uni_full;
        else if (is_c)     in_rdy = (state == C_IDLE);
        else if (is_bcast) in_rdy = ~|full;
        else               in_rdy = 1'b1;
        accept = in_vld && in_rdy;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            push[i] = accept && (is_bcast || (is_uni && in_dest == DESTW'(i)));
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
        bx_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (out_rdy[g]),
            .wdata (in_data),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (out_data[g*DW +: DW])
        );
        assign out_vld[g] = !empty[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= C_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            C_IDLE:  if (accept && is_c) state_nxt = C_REQ;
            C_REQ:   if (c_ack)          state_nxt = C_REL;
            C_REL:   if (!c_ack)         state_nxt = C_IDLE;
            default:                     state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        c_req = (state == C_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_data   <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && is_c)    c_data   <= in_data;
            if (accept && is_drop) drop_cnt <= bx_sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_block_bx_router.sv
// Directed bench for block_bx_router: scoreboard queues filled by stimulus, drained by monitors.
module tb_block_bx_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic [3:0]  in_dest;
    logic [1:0]  out_vld;
    logic [1:0]  out_rdy;
    logic [63:0] out_data;
    logic        c_req;
    logic        c_ack;
    logic [31:0] c_data;
    logic [15:0] drop_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned exp_drop = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] qc[$];
    logic        prev_req = 1'b0;

    block_bx_router #(.NUM_OUT(2), .DW(32), .DEPTH(4), .DESTW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .c_req    (c_req),
        .c_ack    (c_ack),
        .c_data   (c_data),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_chan(input int ch);
        logic [31:0] got;
        got = (ch == 0) ? out_data[31:0] : out_data[63:32];
        if (ch == 0 && q0.size() > 0)      chk("chan0_data", 64'(got), 64'(q0.pop_front()));
        else if (ch == 1 && q1.size() > 0) chk("chan1_data", 64'(got), 64'(q1.pop_front()));
        else chk($sformatf("chan%0d_unexpected_pop", ch), 64'(got), 64'hDEAD_0000_0000_0000);
    endtask

    // Handshakes seen on the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld[0] && out_rdy[0]) mon_chan(0);
            if (out_vld[1] && out_rdy[1]) mon_chan(1);
            if (c_req && !prev_req) begin
                if (qc.size() > 0) chk("c_data", 64'(c_data), 64'(qc.pop_front()));
                else chk("c_unexpected_req", 64'(c_data), 64'hDEAD_0000_0000_0000);
            end
        end
        prev_req = c_req;
    end

    task automatic send(input logic [3:0] d, input logic [31:0] v);
        int unsigned t = 0;
        in_dest = d;
        in_data = v;
        in_vld  = 1'b1;
        @(negedge clk);
        while (!in_rdy && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            chk("send_timeout", 64'(in_rdy), 64'd1);
        end else begin
            if (d == 4'd0) q0.push_back(v);
            else if (d == 4'd1) q1.push_back(v);
            else if (d == 4'd2) qc.push_back(v);
            else if (d == 4'hF) begin
                q0.push_back(v);
                q1.push_back(v);
            end else if (exp_drop < 16'hFFFF) exp_drop++;
        end
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((q0.size() + q1.size() + qc.size()) != 0 && t < 100) begin
            t++;
            @(posedge clk);
        end
        #1;
        chk("drain_pending", 64'(q0.size() + q1.size() + qc.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; in_dest = '0; out_rdy = 2'b11; c_ack = 1'b0;
        #2;
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_c_req", 64'(c_req), 64'd0);
        chk("rst_c_data", 64'(c_data), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: unicast to channel 1 appears one cycle after accept
        send(4'd1, 32'hA5);
        chk("t1_out_vld", 64'(out_vld), 64'b10);
        chk("t1_out_data_hi", 64'(out_data[63:32]), 64'hA5);
        drain();

        // 2: channel 0 stalled fills at DEPTH; channel 1 keeps flowing
        out_rdy = 2'b10;
        for (int k = 0; k < 4; k++) send(4'd0, 32'h100 + 32'(k));
        in_dest = 4'd0; in_data = 32'h104; in_vld = 1'b1;
        @(negedge clk);
        chk("t2_full_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        #1 in_vld = 1'b0;
        send(4'd1, 32'h200);
        send(4'd1, 32'h201);
        chk("t2_chan0_held", 64'(out_vld[0]), 64'd1);
        out_rdy = 2'b11;
        send(4'd0, 32'h104);
        drain();

        // 3: broadcast blocked by full channel 1, then released by one pop
        out_rdy = 2'b00;
        for (int k = 0; k < 4; k++) send(4'd1, 32'h300 + 32'(k));
        in_dest = 4'hF; in_data = 32'h11; in_vld = 1'b1;
        @(negedge clk);
        chk("t3_bcast_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t3_no_write", 64'(out_vld), 64'b10);
        @(posedge clk);
        #1 in_vld = 1'b0; out_rdy = 2'b10;
        @(posedge clk);
        #1 out_rdy = 2'b00;
        send(4'hF, 32'h11);
        chk("t3_both_vld", 64'(out_vld), 64'b11);
        out_rdy = 2'b11;
        drain();

        // 4: four-phase C transfer; second beat waits for ack release
        send(4'd2, 32'hBEEF);
        chk("t4_c_req_rise", 64'(c_req), 64'd1);
        repeat (3) @(posedge clk);
        #1 c_ack = 1'b1;
        @(posedge clk);
        #1 chk("t4_c_req_fall", 64'(c_req), 64'd0);
        chk("t4_c_data_hold", 64'(c_data), 64'hBEEF);
        in_dest = 4'd2; in_data = 32'hCAFE; in_vld = 1'b1;
        @(negedge clk);
        chk("t4_stall_a", 64'(in_rdy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_stall_b", 64'(in_rdy), 64'd0);
        @(posedge clk);
        #1 c_ack = 1'b0; in_vld = 1'b0;
        send(4'd2, 32'hCAFE);
        chk("t4_second_req", 64'(c_req), 64'd1);
        @(posedge clk);
        #1 c_ack = 1'b1;
        @(posedge clk);
        #1 c_ack = 1'b0;
        @(posedge clk);
        #1 chk("t4_idle_again", 64'(c_req), 64'd0);
        drain();

        // 5: invalid destination is dropped and counted, saturating
        for (int k = 0; k < 3; k++) send(4'd5, 32'h500 + 32'(k));
        chk("t5_drop3", 64'(drop_cnt), 64'(exp_drop));
        chk("t5_drop3_const", 64'(drop_cnt), 64'd3);
        chk("t5_no_out", 64'({c_req, out_vld}), 64'd0);
        in_dest = 4'd5; in_vld = 1'b1;
        repeat (65531) @(posedge clk);
        #1 in_vld = 1'b0;
        exp_drop += 65531;
        chk("t5_preload", 64'(drop_cnt), 64'hFFFE);
        for (int k = 0; k < 3; k++) send(4'd5, 32'h5F0 + 32'(k));
        chk("t5_saturate", 64'(drop_cnt), 64'hFFFF);

        // 6: asynchronous reset with traffic in flight
        out_rdy = 2'b00;
        send(4'd0, 32'h60); send(4'd0, 32'h61);
        send(4'd1, 32'h62); send(4'd1, 32'h63);
        send(4'd2, 32'h64);
        chk("t6_pre_req", 64'(c_req), 64'd1);
        chk("t6_pre_vld", 64'(out_vld), 64'b11);
        in_dest = 4'd0; in_vld = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", 64'(out_vld), 64'd0);
        chk("t6_rst_req", 64'(c_req), 64'd0);
        chk("t6_rst_in_rdy", 64'(in_rdy), 64'd0);
        in_vld = 1'b0;
        q0.delete(); q1.delete(); qc.delete();
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_dest = 4'd2;
        @(negedge clk);
        chk("t6_post_vld", 64'(out_vld), 64'd0);
        chk("t6_post_c_idle", 64'(in_rdy), 64'd1);
        chk("t6_post_drop", 64'(drop_cnt), 64'd0);
        chk("t6_post_c_data", 64'(c_data), 64'd0);
        out_rdy = 2'b11;
        @(posedge clk);
        #1 send(4'd0, 32'h600);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
